// File: rtl/pd_pulse_seq_coder_if.sv
// Bundles the pulse sequencer's strobe, config, flag and status signals.
// slave = the coder itself, master = whatever drives it.
interface pd_pulse_seq_coder_if #(
    parameter int CH = 6,
    parameter int CW = 16,
    parameter int AW = 4
);
    logic          tick;
    logic          cfg_load;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          start;
    logic          abort;
    logic          pluse_start;
    logic          bb_ch;
    logic          tetw_pluse;
    logic [CH+2:0] i;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;

    modport slave (
        input  tick, cfg_load, cfg_addr, cfg_data, start, abort,
               pluse_start, bb_ch, tetw_pluse,
        output i, count, busy, done
    );

    modport master (
        output tick, cfg_load, cfg_addr, cfg_data, start, abort,
               pluse_start, bb_ch, tetw_pluse,
        input  i, count, busy, done
    );
endinterface

// File: rtl/pd_pulse_seq_coder.sv
// Tick-driven sequence counter with CH compare points stretched into pulses, packed into control word i.
// Latency: a match on a tick shows in i on that same tick edge; done/busy are registered state decodes.
// No backpressure: tick/start/abort/cfg strobes are always accepted.
module pd_pulse_seq_coder #(
    parameter int CH = 6,
    parameter int CW = 16,
    parameter int AW = 4
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    pd_pulse_seq_coder_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_seq_tick;
    logic          w_abort_run;

    logic [CH-1:0] r_mask;
    logic [CW-1:0] r_term;
    logic [CW-1:0] r_cmp   [CH];
    logic [CW-1:0] r_width [CH];
    logic [CW-1:0] r_rem   [CH];
    logic [CW-1:0] w_rem_nxt [CH];
    logic [CH-1:0] w_match;
    logic [CH-1:0] w_ch_pulse;
    logic [CH+2:0] r_i;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_seq_tick  = 1'b0;
        w_abort_run = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_count_nxt = '0;
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // abort wins over a coincident tick
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                    w_abort_run = 1'b1;
                end else if (bus.tick) begin
                    w_seq_tick = 1'b1;
                    if (r_count == r_term) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_count_nxt = r_count + CW'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_match    = '0;
        w_ch_pulse = '0;
        for (int k = 0; k < CH; k++) begin
            w_rem_nxt[k] = r_rem[k];
            w_match[k]   = w_seq_tick & r_mask[k] & (r_count == r_cmp[k]);
            if (w_abort_run) begin
                w_rem_nxt[k] = '0;
            end else if (bus.tick) begin
                if (w_match[k]) begin
                    w_rem_nxt[k] = (r_width[k] == '0) ? CW'(1) : r_width[k];
                end else if (r_rem[k] != '0) begin
                    w_rem_nxt[k] = r_rem[k] - CW'(1);
                end
            end
            w_ch_pulse[k] = (w_rem_nxt[k] != '0);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_i     <= '0;
            for (int k = 0; k < CH; k++) begin
                r_rem[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            for (int k = 0; k < CH; k++) begin
                r_rem[k] <= w_rem_nxt[k];
            end
            if (bus.tick) begin
                r_i <= {bus.tetw_pluse, w_ch_pulse, bus.bb_ch, bus.pluse_start};
            end else if (w_abort_run) begin
                r_i[CH:1] <= '0;
            end
        end
    end

    // Config writes land immediately; a tick on the same edge still sees the old values.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_mask <= '0;
            r_term <= '1;
            for (int k = 0; k < CH; k++) begin
                r_cmp[k]   <= '1;
                r_width[k] <= CW'(1);
            end
        end else if (bus.cfg_load) begin
            if (int'(bus.cfg_addr) == 0) begin
                r_mask <= bus.cfg_data[CH-1:0];
            end
            if (int'(bus.cfg_addr) == 1) begin
                r_term <= bus.cfg_data;
            end
            for (int k = 0; k < CH; k++) begin
                if (int'(bus.cfg_addr) == 2 + k) begin
                    r_cmp[k] <= bus.cfg_data;
                end
                if (int'(bus.cfg_addr) == 2 + CH + k) begin
                    r_width[k] <= bus.cfg_data;
                end
            end
        end
    end

    assign bus.i     = r_i;
    assign bus.count = r_count;
    assign bus.busy  = (r_state == S_RUN);
    assign bus.done  = (r_state == S_DONE);
endmodule

// File: tb/tb_pd_pulse_seq_coder.sv
// Directed bench for pd_pulse_seq_coder: tick-numbered reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_pd_pulse_seq_coder;
    localparam int CH = 6;
    localparam int CW = 16;
    localparam int AW = 4;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    pd_pulse_seq_coder_if #(.CH(CH), .CW(CW), .AW(AW)) bus ();

    pd_pulse_seq_coder #(.CH(CH), .CW(CW), .AW(AW)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle / 1 run / 2 done; a pulse is remembered as the last
    // absolute tick number through which it must be high.
    int            ph;
    int            m_count;
    int            m_term;
    logic [CH-1:0] m_mask;
    int            m_cmp [CH];
    int            m_w   [CH];
    longint        tn;
    longint        hi_until [CH];
    logic [CH+2:0] m_i;

    always @(posedge clk_sys) begin
        logic [CH-1:0] ch;
        bit            ab;
        if (!rst_n) begin
            ph = 0; m_count = 0; m_term = 65535; m_mask = '0; tn = 0; m_i = '0;
            for (int k = 0; k < CH; k++) begin
                m_cmp[k] = 65535; m_w[k] = 1; hi_until[k] = -1;
            end
        end else begin
            ab = (ph == 1) && (bus.abort === 1'b1);
            if (bus.tick) tn++;
            case (ph)
                0: if (bus.start) begin ph = 1; m_count = 0; end
                1: begin
                    if (ab) begin
                        ph = 0; m_count = 0;
                        for (int k = 0; k < CH; k++) hi_until[k] = -1;
                    end else if (bus.tick) begin
                        for (int k = 0; k < CH; k++)
                            if (m_mask[k] && m_count == m_cmp[k])
                                hi_until[k] = tn + ((m_w[k] == 0) ? 1 : m_w[k]) - 1;
                        if (m_count == m_term) ph = 2;
                        else m_count++;
                    end
                end
                default: begin ph = 0; m_count = 0; end
            endcase
            if (bus.tick) begin
                for (int k = 0; k < CH; k++) ch[k] = (tn <= hi_until[k]);
                m_i = {bus.tetw_pluse, ch, bus.bb_ch, bus.pluse_start};
            end else if (ab) begin
                m_i[CH:1] = '0;
            end
            if (bus.cfg_load) begin
                if (int'(bus.cfg_addr) == 0) m_mask = bus.cfg_data[CH-1:0];
                if (int'(bus.cfg_addr) == 1) m_term = int'(bus.cfg_data);
                for (int k = 0; k < CH; k++) begin
                    if (int'(bus.cfg_addr) == 2 + k) m_cmp[k] = int'(bus.cfg_data);
                    if (int'(bus.cfg_addr) == 2 + CH + k) m_w[k] = int'(bus.cfg_data);
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        if (chk_en) begin
            chk("model_i",     32'(bus.i),     32'(m_i));
            chk("model_count", 32'(bus.count), 32'(m_count));
            chk("model_busy",  32'(bus.busy),  32'(ph == 1));
            chk("model_done",  32'(bus.done),  32'(ph == 2));
        end
    end

    task automatic clk1();
        @(posedge clk_sys);
        #1;
    endtask

    // one tick followed by three idle clocks
    task automatic tk();
        bus.tick = 1'b1;
        clk1();
        bus.tick = 1'b0;
        repeat (3) clk1();
    endtask

    task automatic wr(input int a, input int d);
        bus.cfg_load = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_data = CW'(d);
        clk1();
        bus.cfg_load = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        clk1();
        bus.start = 1'b0;
        clk1();
    endtask

    // final tick at count==term: done must be a single clk with count held
    task automatic last_tick(input string tag, input int term);
        bus.tick = 1'b1;
        clk1();
        bus.tick = 1'b0;
        chk({tag, "_done_hi"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
        chk({tag, "_cnt_held"}, 32'(bus.count), 32'(term));
        clk1();
        chk({tag, "_done_lo"}, 32'(bus.done), 32'd0);
        chk({tag, "_cnt_zero"}, 32'(bus.count), 32'd0);
    endtask

    initial begin
        bus.tick = 0; bus.cfg_load = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.start = 0; bus.abort = 0; bus.pluse_start = 0; bus.bb_ch = 0; bus.tetw_pluse = 0;
        rst_n = 1'b0;
        clk1();
        chk_en = 1'b1;
        repeat (2) clk1();
        rst_n = 1'b1;
        clk1();
        chk("rst_i", 32'(bus.i), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);

        // reset mid-RUN, then run with default config: no pulses, term all-ones
        wr(0, 1); wr(1, 12); wr(2, 2); wr(2 + CH, 5);
        go();
        repeat (3) tk();
        chk("pre_rst_i2", 32'(bus.i[2]), 32'd1);
        rst_n = 1'b0;
        repeat (3) clk1();
        chk("midrst_i", 32'(bus.i), 32'd0);
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        clk1();
        go();
        repeat (4) tk();
        chk("dflt_no_pulse", 32'(bus.i[CH:1]), 32'd0);
        chk("dflt_count", 32'(bus.count), 32'd4);
        chk("dflt_busy", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1; clk1(); bus.abort = 1'b0; clk1();

        // basic sequence
        wr(0, 6'b000011); wr(2, 5); wr(3, 9); wr(2 + CH, 3); wr(3 + CH, 1); wr(1, 12);
        go();
        for (int c = 0; c < 12; c++) begin
            tk();
            chk("basic_i2", 32'(bus.i[2]), 32'(c >= 5 && c <= 7));
            chk("basic_i3", 32'(bus.i[3]), 32'(c == 9));
            chk("basic_count", 32'(bus.count), 32'(c + 1));
        end
        last_tick("basic", 12);

        // simultaneous matches, ch1 disabled with the same compare point
        wr(0, 6'b000101); wr(2, 4); wr(3, 4); wr(4, 4); wr(2 + CH, 2); wr(4 + CH, 2); wr(1, 6);
        go();
        for (int c = 0; c < 6; c++) begin
            tk();
            chk("simul_i2", 32'(bus.i[2]), 32'(c >= 4));
            chk("simul_i4", 32'(bus.i[4]), 32'(c >= 4));
            chk("simul_i3_off", 32'(bus.i[3]), 32'd0);
        end
        last_tick("simul", 6);

        // width 0 and retrigger via cmp rewrite during RUN
        wr(0, 6'b000011); wr(2, 2); wr(2 + CH, 0); wr(3, 3); wr(3 + CH, 4); wr(1, 10);
        go();
        for (int c = 0; c < 10; c++) begin
            tk();
            if (c == 3) wr(3, 5);
            chk("w0_i2", 32'(bus.i[2]), 32'(c == 2));
            chk("retrig_i3", 32'(bus.i[3]), 32'(c >= 3 && c <= 8));
        end
        last_tick("retrig", 10);

        // abort coincident with tick at count 6 while ch0 pulse active
        wr(0, 6'b000001); wr(2, 5); wr(2 + CH, 3); wr(1, 12);
        go();
        for (int c = 0; c < 6; c++) tk();
        chk("abort_pre_i2", 32'(bus.i[2]), 32'd1);
        chk("abort_pre_cnt", 32'(bus.count), 32'd6);
        bus.abort = 1'b1; bus.tick = 1'b1;
        clk1();
        bus.abort = 1'b0; bus.tick = 1'b0;
        chk("abort_count", 32'(bus.count), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_pulses", 32'(bus.i[CH:1]), 32'd0);
        clk1();
        chk("abort_no_done", 32'(bus.done), 32'd0);
        tk();
        chk("abort_idle_i2", 32'(bus.i[2]), 32'd0);

        // flag passthrough only on tick edges
        tk();
        bus.pluse_start = 1'b1; bus.bb_ch = 1'b1; bus.tetw_pluse = 1'b1;
        clk1(); clk1();
        chk("pass_hold0", 32'({bus.i[CH+2], bus.i[1], bus.i[0]}), 32'b000);
        tk();
        chk("pass_set", 32'({bus.i[CH+2], bus.i[1], bus.i[0]}), 32'b111);
        bus.pluse_start = 1'b0; bus.tetw_pluse = 1'b0;
        clk1();
        chk("pass_hold1", 32'({bus.i[CH+2], bus.i[1], bus.i[0]}), 32'b111);
        tk();
        chk("pass_mix", 32'({bus.i[CH+2], bus.i[1], bus.i[0]}), 32'b010);
        bus.bb_ch = 1'b0;
        tk();

        // term=0: one-tick RUN, count-0 match fires and finishes in IDLE
        wr(1, 0); wr(0, 6'b000001); wr(2, 0); wr(2 + CH, 2);
        go();
        bus.tick = 1'b1;
        clk1();
        bus.tick = 1'b0;
        chk("t0_done", 32'(bus.done), 32'd1);
        chk("t0_i2", 32'(bus.i[2]), 32'd1);
        chk("t0_count", 32'(bus.count), 32'd0);
        clk1();
        chk("t0_done_lo", 32'(bus.done), 32'd0);
        tk();
        chk("t0_idle_i2_on", 32'(bus.i[2]), 32'd1);
        tk();
        chk("t0_idle_i2_off", 32'(bus.i[2]), 32'd0);

        // start during RUN is ignored
        wr(1, 5); wr(0, 0);
        go();
        tk(); tk();
        chk("sr_count_a", 32'(bus.count), 32'd2);
        bus.start = 1'b1; clk1(); bus.start = 1'b0;
        chk("sr_count_b", 32'(bus.count), 32'd2);
        chk("sr_busy", 32'(bus.busy), 32'd1);
        tk();
        chk("sr_count_c", 32'(bus.count), 32'd3);
        bus.abort = 1'b1; clk1(); bus.abort = 1'b0;
        chk("sr_abort_busy", 32'(bus.busy), 32'd0);
        repeat (2) clk1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pd_pulse_seq_coder.md
Name: pd_pulse_seq_coder

Overview:
- Parametrised successor to the pulse-decoder stage of the NMR pulse sequencer.
- Owns its own sequence counter, advanced by a DDS-derived tick strobe.
- Compares the counter against CH programmable compare points.
- Stretches each match into a programmable-width pulse.
- Packs the pulses with the start, bb_ch and tetw_pluse flags into one registered control word for the TX/RX switching logic.
- Unlike its predecessor, it:
  - has per-channel enables,
  - has per-channel pulse width,
  - allows simultaneous matches with no priority,
  - has a programmable terminal count and start/abort/done sequencing.

Parameters:
- CH, 6, number of compare/pulse channels (1..14).
- CW, 16, counter, compare and cfg_data width.
- AW, 4, cfg_addr width; must satisfy 2^AW >= 2*CH+2.

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- tick  in  1  one-clk_sys strobe per DDS period; all sequencing advances only on tick.
- cfg_load  in  1  config write strobe.
- cfg_addr  in  AW  config address.
- cfg_data  in  CW  config write data.
- start  in  1  start-sequence pulse.
- abort  in  1  abort pulse.
- pluse_start  in  1  flag, passed through into i.
- bb_ch  in  1  flag, passed through into i.
- tetw_pluse  in  1  flag, passed through into i.
- i  out  CH+3  {tetw_pluse, ch_pulse[CH-1:0], bb_ch, pluse_start}, registered.
- count  out  CW  current sequence count.
- busy  out  1  high in RUN.
- done  out  1  one-clk pulse on sequence completion.

Behaviour:
- Reset (rst_n=0 at a clk_sys edge):
  - i=0, count=0, busy=0, done=0, state IDLE.
  - enable mask=0, term=all-ones, every cmp=all-ones, every width=1, every remaining-counter rem_k=0.
- Config map (write on cfg_load=1, any state):
  - 0 = enable mask (bits CH-1:0 used).
  - 1 = term.
  - 2+k = cmp[k].
  - 2+CH+k = width[k].
  - Other addresses are ignored.
  - A write takes effect from the next tick.
- FSM states: IDLE, RUN, DONE.
  - IDLE: count held at 0. start=1 -> RUN next clk, count=0. abort has no effect.
  - RUN, on a tick with count=c:
    - evaluate matches using c;
    - if c==term -> DONE, count holds c;
    - otherwise count<=c+1.
  - RUN, abort=1 (with or without tick): -> IDLE; count=0, all rem_k=0, ch_pulse bits in i cleared on the same edge. Abort has priority over tick.
  - start while in RUN or DONE is ignored.
  - DONE: done=1 for exactly one clk, then IDLE with count=0.
  - busy=1 iff state==RUN.
- Match rule: match_k = RUN & tick & mask[k] & (count==cmp[k]). Any number of channels may match on the same tick; no priority.
- Stretch rule, applied on each tick in any state:
  - rem_k <= match_k ? max(width[k],1) : (rem_k!=0 ? rem_k-1 : 0).
  - ch_pulse[k] = (new rem_k != 0).
  - Result: a pulse is high for exactly max(width,1) ticks.
  - A re-match while the pulse is active reloads the count.
  - Pulses still active at DONE run to completion in IDLE.
- i register:
  - Updated only on tick edges with the new ch_pulse and the tick-sampled flag inputs; holds between ticks.
  - Latency: match at tick n -> i bit high from the clk edge of tick n, through tick n+W-1; low after tick n+W.
- term=0: RUN lasts one tick; the count=0 match still fires.
- cmp[k] > term: channel k never fires.
- Counter cannot wrap, since count stops at term <= 2^CW-1.

Test Plan:
- Reset defaults: assert rst_n=0 for 3 clks mid-RUN -> i=0, count=0, busy=0, done=0, and no pulse after release with no config.
- Basic sequence:
  - Config: mask=0b000011, cmp0=5, cmp1=9, width0=3, width1=1, term=12.
  - Action: start, ticks every 4 clks.
  - Required: i[2] high for ticks 5..7; i[3] high at tick 9 only; done is a single clk after the tick at count=12; busy low after.
- Simultaneous matches: cmp0=cmp2=4, both enabled -> i[2] and i[4] rise on the same tick edge. A disabled channel with cmp=4 stays low.
- Retrigger and width 0:
  - width0=0 -> pulse is 1 tick.
  - width1=4 with cmp re-written from 3 to 5 during RUN (after the match at 3, before tick 5) -> pulse extends through tick 8.
- Abort: abort coincident with a tick at count=6 while i[2] is active -> next clk count=0, IDLE, ch_pulse all 0, no done.
- Passthrough and edge cases:
  - Toggle pluse_start/bb_ch/tetw_pluse between ticks -> i[0], i[1], i[CH+2] change only on tick edges.
  - term=0 -> done after the first tick.
  - start during RUN -> ignored (count continues).
